// File: rtl/mii_rx_framer_if.sv
// ---------------------------------------------------------------------
// mii_rx_framer_if : MII receive nibble pins plus received byte stream
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

interface mii_rx_framer_if;
  logic [3:0]  phy_rxd;
  logic        phy_rxctl;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        rx_err;
  logic [15:0] rx_frame_cnt;
  logic [15:0] rx_err_cnt;

  modport master (
    input  phy_rxd, phy_rxctl,
    output rx_data, rx_valid, rx_last, rx_err, rx_frame_cnt, rx_err_cnt
  );

  modport slave (
    output phy_rxd, phy_rxctl,
    input  rx_data, rx_valid, rx_last, rx_err, rx_frame_cnt, rx_err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mii_rx_framer.sv
// ---------------------------------------------------------------------
// mii_rx_framer : MII receive framer, strips preamble/SFD, emits bytes
//                 with FCS, length and alignment error flag.
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module mii_rx_framer #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mii_rx_framer_if.master     bus
);

  localparam int          CNT_W     = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_GOOD  = 32'hDEBB_20E3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] b);
    logic [31:0] c;
    c = crc_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [3:0]       rxd_q;
  logic             rxctl_q;
  logic [1:0]       state_q, state_d;
  logic             phase_q, phase_d;
  logic [3:0]       lo_q, lo_d;
  logic [7:0]       held_q, held_d;
  logic             held_vld_q, held_vld_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_last_q, rx_last_d;
  logic             rx_err_q, rx_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic       in_data;
  logic       byte_done;
  logic       oversize;
  logic       frame_end;
  logic       end_err;
  logic       sfd_seen;
  logic [7:0] new_byte;

  assign in_data   = (state_q == ST_DATA);
  assign byte_done = in_data && rxctl_q && phase_q;
  assign oversize  = byte_done && (byte_cnt_q == CNT_W'(MAX_FRAME_BYTES));
  assign frame_end = in_data && !rxctl_q;
  assign sfd_seen  = (state_q == ST_PREAMBLE) && rxctl_q && (rxd_q == 4'hD);
  assign new_byte  = {rxd_q, lo_q};
  // The CRC register already covers the held byte, so it is checked as-is at end of frame.
  assign end_err   = (crc_q != CRC_GOOD) || phase_q || (byte_cnt_q < CNT_W'(MIN_FRAME_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q       <= 4'h0;
      rxctl_q     <= 1'b0;
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      lo_q        <= 4'h0;
      held_q      <= 8'h00;
      held_vld_q  <= 1'b0;
      byte_cnt_q  <= '0;
      crc_q       <= CRC_INIT;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      rx_err_q    <= 1'b0;
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      rxd_q       <= bus.phy_rxd;
      rxctl_q     <= bus.phy_rxctl;
      state_q     <= state_d;
      phase_q     <= phase_d;
      lo_q        <= lo_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_last_q   <= rx_last_d;
      rx_err_q    <= rx_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rxctl_q) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (!rxctl_q)            state_d = ST_IDLE;
        else if (rxd_q == 4'h5)  state_d = ST_PREAMBLE;
        else if (rxd_q == 4'hD)  state_d = ST_DATA;
        else                     state_d = ST_DROP;
      end
      ST_DATA: begin
        if (!rxctl_q)     state_d = ST_IDLE;
        else if (oversize) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (!rxctl_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    lo_d        = lo_q;
    held_d      = held_q;
    held_vld_d  = held_vld_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_last_d   = 1'b0;
    rx_err_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (sfd_seen) begin
      phase_d    = 1'b0;
      byte_cnt_d = '0;
      crc_d      = CRC_INIT;
      held_vld_d = 1'b0;
    end

    if (in_data && rxctl_q && !phase_q) begin
      lo_d    = rxd_q;
      phase_d = 1'b1;
    end

    if (byte_done) begin
      phase_d = 1'b0;
      if (oversize) begin
        rx_data_d  = held_q;
        rx_valid_d = 1'b1;
        rx_last_d  = 1'b1;
        rx_err_d   = 1'b1;
        err_cnt_d  = sat_inc(err_cnt_q);
        held_vld_d = 1'b0;
      end else begin
        if (held_vld_q) begin
          rx_data_d  = held_q;
          rx_valid_d = 1'b1;
        end
        held_d     = new_byte;
        held_vld_d = 1'b1;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        crc_d      = crc_byte(crc_q, new_byte);
      end
    end

    // A frame with no completed byte still terminates from DATA and counts as bad.
    if (frame_end) begin
      held_vld_d = 1'b0;
      if (held_vld_q) begin
        rx_data_d  = held_q;
        rx_valid_d = 1'b1;
        rx_last_d  = 1'b1;
        rx_err_d   = end_err;
        if (end_err) err_cnt_d   = sat_inc(err_cnt_q);
        else         frame_cnt_d = sat_inc(frame_cnt_q);
      end else begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_last      = rx_last_q;
  assign bus.rx_err       = rx_err_q;
  assign bus.rx_frame_cnt = frame_cnt_q;
  assign bus.rx_err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mii_rx_framer.sv
// ---------------------------------------------------------------------
// tb_mii_rx_framer : directed self-checking bench for mii_rx_framer
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_mii_rx_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mii_rx_framer_if bus ();

  mii_rx_framer #(
    .MIN_FRAME_BYTES(64),
    .MAX_FRAME_BYTES(1518)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int         strobes   = 0;
  int         lasts     = 0;
  int         bad_flags = 0;
  logic       last_err  = 1'b0;
  logic [7:0] cap [0:4095];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      cap[strobes[11:0]] = bus.rx_data;
      strobes++;
      if (bus.rx_last === 1'b1) begin
        lasts++;
        last_err = bus.rx_err;
      end
    end else if (bus.rx_last === 1'b1 || bus.rx_err === 1'b1) begin
      bad_flags++;
    end
  end

  logic [7:0] fr [0:1599];
  int         fr_len;
  int         sb, lb, snap;

  task automatic build(input int n, input bit with_fcs);
    logic [31:0] crc;
    logic        fb;
    for (int i = 0; i < n; i++) fr[i] = i[7:0];
    fr_len = n;
    if (with_fcs) begin
      crc = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 8; k++) begin
          fb  = crc[0] ^ fr[i][k];
          crc = crc >> 1;
          if (fb) crc = crc ^ 32'hEDB8_8320;
        end
      end
      crc = ~crc;
      fr[n]   = crc[7:0];
      fr[n+1] = crc[15:8];
      fr[n+2] = crc[23:16];
      fr[n+3] = crc[31:24];
      fr_len  = n + 4;
    end
  endtask

  task automatic send_nib(input logic [3:0] n, input logic ctl);
    @(posedge clk);
    #1;
    bus.phy_rxd   = n;
    bus.phy_rxctl = ctl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_nib(4'h0, 1'b0);
  endtask

  task automatic mark;
    sb = strobes;
    lb = lasts;
  endtask

  // rst_at < 0 means no reset pulse during the frame
  task automatic send_frame(input bit dribble, input int rst_at);
    for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b1);
    send_nib(4'hD, 1'b1);
    for (int i = 0; i < fr_len; i++) begin
      if (i == rst_at)     rst = 1'b1;
      if (i == rst_at + 1) rst = 1'b0;
      if (rst_at >= 0 && i == rst_at + 2) snap = strobes;
      send_nib(fr[i][3:0], 1'b1);
      send_nib(fr[i][7:4], 1'b1);
    end
    if (dribble) send_nib(4'hA, 1'b1);
    idle(6);
  endtask

  initial begin
    bus.phy_rxd   = 4'h0;
    bus.phy_rxctl = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("rst_last",  {31'b0, bus.rx_last},  32'd0);
    check("rst_err",   {31'b0, bus.rx_err},   32'd0);
    check("rst_data",  {24'b0, bus.rx_data},  32'd0);
    check("rst_fcnt",  {16'b0, bus.rx_frame_cnt}, 32'd0);
    check("rst_ecnt",  {16'b0, bus.rx_err_cnt},   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);

    // good 64-byte frame
    build(60, 1'b1);
    mark();
    send_frame(1'b0, -1);
    check("good_strobes", strobes - sb, 32'd64);
    check("good_lasts",   lasts - lb,   32'd1);
    check("good_err",     {31'b0, last_err}, 32'd0);
    check("good_fcnt",    {16'b0, bus.rx_frame_cnt}, 32'd1);
    check("good_ecnt",    {16'b0, bus.rx_err_cnt},   32'd0);
    check("good_byte0",   {24'b0, cap[sb[11:0]]},        32'h00);
    check("good_byte59",  {24'b0, cap[(sb + 59) % 4096]}, 32'h3B);
    check("good_fcs3",    {24'b0, cap[(sb + 63) % 4096]}, {24'b0, fr[63]});

    // same frame with a flipped payload bit
    fr[10] = fr[10] ^ 8'h04;
    mark();
    send_frame(1'b0, -1);
    check("flip_strobes", strobes - sb, 32'd64);
    check("flip_err",     {31'b0, last_err}, 32'd1);
    check("flip_ecnt",    {16'b0, bus.rx_err_cnt},   32'd1);
    check("flip_fcnt",    {16'b0, bus.rx_frame_cnt}, 32'd1);

    // 40-byte frame with valid FCS is short
    build(36, 1'b1);
    mark();
    send_frame(1'b0, -1);
    check("short_strobes", strobes - sb, 32'd40);
    check("short_err",     {31'b0, last_err}, 32'd1);
    check("short_ecnt",    {16'b0, bus.rx_err_cnt}, 32'd2);

    // good frame plus a dribble nibble
    build(60, 1'b1);
    mark();
    send_frame(1'b1, -1);
    check("odd_strobes", strobes - sb, 32'd64);
    check("odd_err",     {31'b0, last_err}, 32'd1);
    check("odd_ecnt",    {16'b0, bus.rx_err_cnt}, 32'd3);

    // 1600-byte burst truncated at 1518
    build(1600, 1'b0);
    mark();
    send_frame(1'b0, -1);
    check("big_strobes", strobes - sb, 32'd1518);
    check("big_lasts",   lasts - lb,   32'd1);
    check("big_err",     {31'b0, last_err}, 32'd1);
    check("big_lastbyte", {24'b0, cap[(sb + 1517) % 4096]}, {24'b0, 8'(1517)});
    check("big_ecnt",    {16'b0, bus.rx_err_cnt},   32'd4);
    check("big_fcnt",    {16'b0, bus.rx_frame_cnt}, 32'd1);

    build(60, 1'b1);
    mark();
    send_frame(1'b0, -1);
    check("after_big_strobes", strobes - sb, 32'd64);
    check("after_big_err",     {31'b0, last_err}, 32'd0);
    check("after_big_fcnt",    {16'b0, bus.rx_frame_cnt}, 32'd2);

    // bad preamble nibble then junk that looks like a preamble and SFD
    mark();
    send_nib(4'h5, 1'b1);
    send_nib(4'h5, 1'b1);
    send_nib(4'h3, 1'b1);
    for (int i = 0; i < 8; i++) send_nib(4'h5, 1'b1);
    send_nib(4'hD, 1'b1);
    for (int i = 0; i < 20; i++) send_nib(i[3:0], 1'b1);
    idle(6);
    check("junk_strobes", strobes - sb, 32'd0);
    check("junk_fcnt",    {16'b0, bus.rx_frame_cnt}, 32'd2);
    check("junk_ecnt",    {16'b0, bus.rx_err_cnt},   32'd4);

    // rxctl falls before SFD
    mark();
    for (int i = 0; i < 6; i++) send_nib(4'h5, 1'b1);
    idle(6);
    check("nosfd_strobes", strobes - sb, 32'd0);
    check("nosfd_ecnt",    {16'b0, bus.rx_err_cnt}, 32'd4);

    // reset pulsed at byte 30
    build(60, 1'b1);
    mark();
    send_frame(1'b0, 30);
    check("rst_mid_strobes", strobes - snap, 32'd0);
    check("rst_mid_lasts",   lasts - lb,     32'd0);
    check("rst_mid_fcnt",    {16'b0, bus.rx_frame_cnt}, 32'd0);
    check("rst_mid_ecnt",    {16'b0, bus.rx_err_cnt},   32'd0);

    mark();
    send_frame(1'b0, -1);
    check("post_rst_strobes", strobes - sb, 32'd64);
    check("post_rst_err",     {31'b0, last_err}, 32'd0);
    check("post_rst_fcnt",    {16'b0, bus.rx_frame_cnt}, 32'd1);
    check("post_rst_byte30",  {24'b0, cap[(sb + 30) % 4096]}, 32'h1E);

    check("flag_without_valid", bad_flags, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
